imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Registered, parametrised immediate extender for the pipelined datapath: IMM_W-bit field -> DATA_W-bit operand.
//  Per-transaction mode: zero-extend, sign-extend, or upper-load (immediate placed in the MSBs, low bits zero).
//  Valid/ready on both sides, 2-entry skid so in_ready is registered. Sits between decode and the ALU B-mux.
// PARAMETERS
//  IMM_W   16  immediate field width (1..DATA_W-1)
//  DATA_W  32  extended operand width
//  TAG_W   5   sideband tag (e.g. dest reg) carried alongside, unmodified
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       upstream has an immediate
//  in_ready     out  1       stage can accept; registered
//  in_imm       in   IMM_W   raw immediate field
//  in_mode      in   2       00 ZERO, 01 SIGN, 10 UPPER, 11 reserved
//  in_tag       in   TAG_W   sideband, passed through
//  out_valid    out  1       out_data/out_tag valid
//  out_ready    in   1       downstream accepts
//  out_data     out  DATA_W  extended operand
//  out_tag      out  TAG_W   tag of the same transaction
//  out_bad_mode out  1       qualifies out_valid: transaction used mode 11
//  ext_count    out  16      [IMM_EXT_STATS_EN only] accepted-transaction count
// BEHAVIOUR
//  - Transfer when valid&&ready on a rising edge. Latency 1: input accepted at edge N appears at out_* after edge N.
//  - Extension computed on the input side, registered into output/skid. No combinational in->out path.
//  - ZERO: {(DATA_W-IMM_W)'0, imm}. SIGN: {(DATA_W-IMM_W){imm[IMM_W-1]}, imm}.
//    UPPER: imm in the top IMM_W bits, rest 0 (for the defaults: imm<<16).
//  - Reserved 11: out_data computed as ZERO, out_bad_mode=1 for that transaction only.
//  - Storage: output reg (OUT) + skid reg (SKD). FSM states:
//    EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
//    ONE:   out_valid=1, in_ready=1.
//           accept&&!drain -> FULL (new item into SKD).
//           accept&&drain  -> ONE (new item into OUT).
//           drain only     -> EMPTY.
//    FULL:  out_valid=1, in_ready=0. drain -> ONE (SKD moves to OUT). Input ignored while in_ready=0.
//  - Order strictly FIFO. Each item is presented exactly once. out_* hold stable while out_valid&&!out_ready.
//  - Reset: state EMPTY; out_valid=0; in_ready=0 during reset, 1 on the first cycle after; out_data=0; out_tag=0;
//    out_bad_mode=0; ext_count=0. Reset mid-transfer discards OUT and SKD, so no item is emitted after reset.
// CONFIGURATION
//  IMM_EXT_STATS_EN defined:
//   - ext_count increments on every input handshake and saturates at 16'hFFFF (no wrap). Cleared by reset.
//  Not defined:
//   - ext_count port absent. No counter logic.
//  Datapath and timing are identical either way.
// STRUCTURE
//  - Shared package mips_ext_pkg: mode encodings (EXT_ZERO/EXT_SIGN/EXT_UPPER/EXT_RSVD), FSM state encodings
//    (ST_EMPTY/ST_ONE/ST_FULL), 2-bit widths.
//  - One sub-module imm_extend_comb: pure combinational (imm, mode) -> (data, bad_mode), parametrised IMM_W/DATA_W.
//    Holds the shared successor of the plain zero-extender.
//  - imm_extend_pipe holds the FSM, OUT/SKD registers and the optional counter.
// TESTING
//  1. Each mode, out_ready=1, in_imm=16'h8001:
//     ZERO->32'h00008001; SIGN->32'hFFFF8001; UPPER->32'h80010000; all one cycle after accept.
//  2. in_mode=11, in_imm=16'hFFFF -> out_data=32'h0000FFFF, out_bad_mode=1. Next ZERO item -> out_bad_mode=0.
//  3. Backpressure: out_ready=0, send tags 1,2,3 back-to-back:
//     in_ready falls after the 2nd accept; tag 3 held. Release -> tags 1,2,3 in order, no loss or duplication.
//  4. Streaming: in_valid=out_ready=1 for 100 cycles, random imm/mode -> 100 outputs, 1/cycle,
//     matching the reference model. in_ready stays 1.
//  5. Reset while FULL (out_ready=0, two items held):
//     out_valid=0 next cycle, in_ready=1 one cycle after reset drops, stale items never appear.
//  6. IMM_EXT_STATS_EN with ext_count preloaded near max (force 16'hFFFE), 3 accepts -> 16'hFFFF, stays.
//     Also IMM_W=12, DATA_W=64 SIGN of 12'h800 -> 64'hFFFFFFFFFFFFF800.

Source files
------------

// File: rtl/mips_ext_pkg.sv
// Shared encodings for the immediate-extension pipeline.
//   ext_mode_e  : per-transaction extension mode (2 bits)
//   ext_state_e : output-stage occupancy FSM (2 bits)
package mips_ext_pkg;
  localparam int MODE_W = 2;
  localparam int ST_W   = 2;

  typedef enum logic [MODE_W-1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_RSVD  = 2'b11
  } ext_mode_e;

  typedef enum logic [ST_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } ext_state_e;
endpackage

// File: rtl/imm_extend_comb.sv
// Pure combinational immediate extender.
// Ports:
//   imm_i      : IMM_W-bit raw immediate
//   mode_i     : extension mode (ext_mode_e encoding)
//   data_o     : DATA_W-bit extended operand
//   bad_mode_o : mode was the reserved encoding
module imm_extend_comb
  import mips_ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [MODE_W-1:0] mode_i,
  output logic [DATA_W-1:0] data_o,
  output logic              bad_mode_o
);
  logic [DATA_W-1:0] zext;

  // Zero extension is the base; the other modes are derived from it.
  assign zext = {{(DATA_W-IMM_W){1'b0}}, imm_i};

  always_comb begin
    data_o     = zext;
    bad_mode_o = 1'b0;
    case (ext_mode_e'(mode_i))
      EXT_ZERO:  data_o = zext;
      EXT_SIGN:  data_o = {{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i};
      EXT_UPPER: data_o = zext << (DATA_W-IMM_W);
      EXT_RSVD:  begin
        // Reserved mode still yields a usable (zero-extended) value; the
        // flag lets the consumer raise an illegal-instruction condition.
        data_o     = zext;
        bad_mode_o = 1'b1;
      end
      default:   data_o = zext;
    endcase
  end
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with valid/ready on both sides and a
// 2-entry (OUT + skid) buffer so in_ready comes straight from a flop.
// Optional macro IMM_EXT_STATS_EN adds a saturating accept counter.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : upstream handshake (in_ready registered)
//   in_imm/in_mode/in_tag : immediate, extension mode, sideband tag
//   out_valid/out_ready   : downstream handshake
//   out_data/out_tag      : extended operand and its tag
//   out_bad_mode          : transaction used the reserved mode
//   ext_count             : accepted-transaction count (IMM_EXT_STATS_EN only)
module imm_extend_pipe
  import mips_ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_bad_mode
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [15:0]       ext_count
`endif
);
  ext_state_e        state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] out_data_q, skd_data_q, new_data;
  logic [TAG_W-1:0]  out_tag_q, skd_tag_q;
  logic              out_bad_q, skd_bad_q, new_bad;
  logic              acc, drain, load_out, load_skd, skd_to_out;

  // Extension happens before the registers: no in->out combinational path.
  imm_extend_comb #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_ext (
    .imm_i      (in_imm),
    .mode_i     (in_mode),
    .data_o     (new_data),
    .bad_mode_o (new_bad)
  );

  assign acc   = in_valid && in_ready_q;
  assign drain = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d    = state_q;
    load_out   = 1'b0;
    load_skd   = 1'b0;
    skd_to_out = 1'b0;
    case (state_q)
      ST_EMPTY: if (acc) begin
        state_d  = ST_ONE;
        load_out = 1'b1;
      end
      ST_ONE: begin
        if (acc && drain) begin
          load_out = 1'b1;
        end else if (acc) begin
          state_d  = ST_FULL;
          load_skd = 1'b1;
        end else if (drain) begin
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: if (drain) begin
        state_d    = ST_ONE;
        skd_to_out = 1'b1;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      out_bad_q  <= 1'b0;
      skd_data_q <= '0;
      skd_tag_q  <= '0;
      skd_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      // in_ready is a look-ahead of next state, so it is a plain flop output.
      in_ready_q <= (state_d != ST_FULL);
      if (load_out) begin
        out_data_q <= new_data;
        out_tag_q  <= in_tag;
        out_bad_q  <= new_bad;
      end else if (skd_to_out) begin
        out_data_q <= skd_data_q;
        out_tag_q  <= skd_tag_q;
        out_bad_q  <= skd_bad_q;
      end
      if (load_skd) begin
        skd_data_q <= new_data;
        skd_tag_q  <= in_tag;
        skd_bad_q  <= new_bad;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != ST_EMPTY);
  assign out_data     = out_data_q;
  assign out_tag      = out_tag_q;
  assign out_bad_mode = out_bad_q;

`ifdef IMM_EXT_STATS_EN
  logic [15:0] ext_count_q;

  always_ff @(posedge clk) begin
    if (reset)                            ext_count_q <= '0;
    else if (acc && (ext_count_q != '1))  ext_count_q <= ext_count_q + 16'd1;
  end

  assign ext_count = ext_count_q;
`endif
endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_bad_mode;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_bad_mode;
  logic [11:0] w_in_imm;
  logic [1:0]  w_in_mode;
  logic [4:0]  w_in_tag, w_out_tag;
  logic [63:0] w_out_data;

`ifdef IMM_EXT_STATS_EN
  logic [15:0] ext_count, w_ext_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_bad_mode(out_bad_mode)
`ifdef IMM_EXT_STATS_EN
    , .ext_count(ext_count)
`endif
  );

  imm_extend_pipe #(.IMM_W(12), .DATA_W(64), .TAG_W(5)) dut_w (
    .clk(clk), .reset(reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_imm(w_in_imm),
    .in_mode(w_in_mode), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_tag(w_out_tag), .out_bad_mode(w_out_bad_mode)
`ifdef IMM_EXT_STATS_EN
    , .ext_count(w_ext_count)
`endif
  );

  // Reference for the default 16 -> 32 configuration.
  function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   return {1'b0, 16'h0000, imm};
      2'b01:   return {1'b0, {16{imm[15]}}, imm};
      2'b10:   return {1'b0, imm, 16'h0000};
      default: return {1'b1, 16'h0000, imm};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one item and returns one cycle after it is accepted.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
    int n;
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_imm = '0; in_mode = '0; in_tag = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_in_imm = '0; w_in_mode = '0; w_in_tag = '0;
    tick(); tick();
    checks++;
    if ({in_ready, out_valid, out_bad_mode, out_tag, out_data} !== 40'h0) begin
      failures++;
      $display("FAIL reset_state: rdy=%0b vld=%0b bad=%0b tag=%0h data=%h required all 0",
               in_ready, out_valid, out_bad_mode, out_tag, out_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready_after: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_modes();
    logic [31:0] exp [3];
    exp[0] = 32'h00008001; exp[1] = 32'hFFFF8001; exp[2] = 32'h80010000;
    out_ready = 1'b1;
    for (int m = 0; m < 3; m++) begin
      send(16'h8001, 2'(m), 5'(m));
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[m] || out_bad_mode !== 1'b0) begin
        failures++;
        $display("FAIL mode_%0d: vld=%0b data=%h bad=%0b required vld=1 data=%h bad=0",
                 m, out_valid, out_data, out_bad_mode, exp[m]);
      end
    end
    tick();
  endtask

  task automatic test_reserved();
    out_ready = 1'b1;
    send(16'hFFFF, 2'b11, 5'd7);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000FFFF || out_bad_mode !== 1'b1) begin
      failures++;
      $display("FAIL rsvd_mode: vld=%0b data=%h bad=%0b required 1 0000ffff 1",
               out_valid, out_data, out_bad_mode);
    end
    send(16'h0001, 2'b00, 5'd8);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h00000001 || out_bad_mode !== 1'b0) begin
      failures++;
      $display("FAIL rsvd_clear: vld=%0b data=%h bad=%0b required 1 00000001 0",
               out_valid, out_data, out_bad_mode);
    end
    tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [4:0] got [$];
    logic acc;
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0011; in_mode = 2'b00; in_tag = 5'd1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_tag !== 5'd1) begin
      failures++; $display("FAIL bp_first: rdy=%0b tag=%0d required 1 1", in_ready, out_tag);
    end
    in_imm = 16'h0022; in_tag = 5'd2;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 5'd1) begin
      failures++;
      $display("FAIL bp_full: rdy=%0b vld=%0b tag=%0d required 0 1 1", in_ready, out_valid, out_tag);
    end
    in_imm = 16'h0033; in_tag = 5'd3;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_tag !== 5'd1 || out_data !== 32'h00000011) begin
      failures++;
      $display("FAIL bp_hold: rdy=%0b tag=%0d data=%h required 0 1 00000011", in_ready, out_tag, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && out_ready) got.push_back(out_tag);
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3 || got[0] !== 5'd1 || got[1] !== 5'd2 || got[2] !== 5'd3) begin
      failures++;
      $display("FAIL bp_order: got %0d items %p required 1,2,3", got.size(), got);
    end
  endtask

  task automatic test_streaming();
    logic [32:0] exp_q [$];
    logic [32:0] e;
    int popped = 0;
    int rdy_bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i <= 100; i++) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stream_extra: unexpected output data=%h", out_data);
        end else begin
          e = exp_q.pop_front();
          popped++;
          if ({out_bad_mode, out_data} !== e) begin
            failures++;
            $display("FAIL stream_item_%0d: bad=%0b data=%h required bad=%0b data=%h",
                     popped, out_bad_mode, out_data, e[32], e[31:0]);
          end
        end
      end
      if (i < 100) begin
        if (in_ready !== 1'b1) rdy_bad++;
        in_valid = 1'b1;
        in_imm   = 16'($urandom);
        in_mode  = 2'($urandom_range(0, 3));
        in_tag   = 5'(i);
        exp_q.push_back(ref_ext(in_imm, in_mode));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    checks++;
    if (popped != 100 || rdy_bad != 0) begin
      failures++;
      $display("FAIL stream_count: outputs=%0d ready_drops=%0d required 100 0", popped, rdy_bad);
    end
    tick();
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'hAAAA; in_mode = 2'b00; in_tag = 5'd20;
    tick();
    in_imm = 16'hBBBB; in_tag = 5'd21;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL rf_setup: rdy=%0b vld=%0b required 0 1", in_ready, out_valid);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin
      failures++;
      $display("FAIL rf_in_reset: vld=%0b rdy=%0b data=%h tag=%0d required 0 0 0 0",
               out_valid, in_ready, out_data, out_tag);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL rf_ready: in_ready=%0b required 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL rf_stale_%0d: out_valid=%0b tag=%0d required 0", i, out_valid, out_tag);
      end
      tick();
    end
  endtask

  task automatic test_wide_sign();
    w_out_ready = 1'b1;
    w_in_valid = 1'b1; w_in_imm = 12'h800; w_in_mode = 2'b01; w_in_tag = 5'd9;
    tick();
    w_in_valid = 1'b0;
    checks++;
    if (w_out_valid !== 1'b1 || w_out_data !== 64'hFFFFFFFFFFFFF800 || w_out_tag !== 5'd9) begin
      failures++;
      $display("FAIL wide_sign: vld=%0b data=%h tag=%0d required 1 fffffffffffff800 9",
               w_out_valid, w_out_data, w_out_tag);
    end
    tick();
  endtask

`ifdef IMM_EXT_STATS_EN
  task automatic test_stats();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (ext_count !== 16'h0) begin
      failures++; $display("FAIL stats_reset: ext_count=%h required 0000", ext_count);
    end
    out_ready = 1'b1; in_imm = 16'h1; in_mode = 2'b00; in_tag = 5'd0;
    in_valid = 1'b1;
    repeat (65534) @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (ext_count !== 16'hFFFE) begin
      failures++; $display("FAIL stats_fffe: ext_count=%h required fffe", ext_count);
    end
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (ext_count !== 16'hFFFF) begin
      failures++; $display("FAIL stats_sat: ext_count=%h required ffff", ext_count);
    end
    tick();
    checks++;
    if (ext_count !== 16'hFFFF) begin
      failures++; $display("FAIL stats_hold: ext_count=%h required ffff", ext_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_modes();
    test_reserved();
    test_backpressure();
    test_streaming();
    test_reset_full();
    test_wide_sign();
`ifdef IMM_EXT_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
